// File: rtl/mux32_arb_pkg.sv
// Shared constants and types for the 32-way round-robin mux arbiter.
//   NUM_REQ     : number of requesters / mux inputs
//   SEL_W       : width of the mux select index
//   arb_state_t : arbiter FSM state encoding
package mux32_arb_pkg;

  localparam int unsigned NUM_REQ = 32;
  localparam int unsigned SEL_W   = 5;

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } arb_state_t;

endpackage

// File: rtl/mux32_arbiter_if.sv
// Request/grant bundle between the requesters and the mux arbiter.
//   req         : request vector, bit i = requester i
//   grant       : one-hot grant back to the requesters
//   grant_valid : some requester currently owns the mux
//   select      : owner index, wired to the mux select port
// Modports: master = requester side, slave = arbiter side.
interface mux32_arbiter_if;
  import mux32_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic [SEL_W-1:0]   select;

  modport master (
    output req,
    input  grant,
    input  grant_valid,
    input  select
  );

  modport slave (
    input  req,
    output grant,
    output grant_valid,
    output select
  );

endinterface

// File: rtl/rr_pick32.sv
// Combinational round-robin pick: first set bit of (req & ~mask) at or
// after 'start', ascending and wrapping 31 -> 0.
//   req   : candidate request vector
//   mask  : bits excluded from the search
//   start : search start index
//   idx   : chosen index (valid when found)
//   found : at least one unmasked request exists
module rr_pick32
  import mux32_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [SEL_W-1:0]   start,
  output logic [SEL_W-1:0]   idx,
  output logic               found
);

  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] rot;
  logic [SEL_W-1:0]   off;

  // Rotate so 'start' lands on bit 0, find lowest set bit, rotate back.
  always_comb begin
    cand = req & ~mask;
    rot  = NUM_REQ'({cand, cand} >> start);
    off  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    found = |cand;
    idx   = start + off;  // 5-bit add wraps modulo 32
  end

endmodule

// File: rtl/mux32_arbiter.sv
// Round-robin arbiter owning the select input of a shared 32:1 mux.
// An owner keeps the grant while it requests, up to MAX_HOLD consecutive
// cycles (0 = unlimited), after which another requester is preferred.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of mux32_arbiter_if (req in; grant/grant_valid/select out)
module mux32_arbiter
  import mux32_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst,
  mux32_arbiter_if.slave  bus
);

  localparam int unsigned HC_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

  arb_state_t         state, state_n;
  logic [SEL_W-1:0]   ptr, ptr_n;
  logic [HC_W-1:0]    hold_cnt, hold_n;
  logic [NUM_REQ-1:0] grant_q, grant_n;
  logic               gv_q, gv_n;
  logic [SEL_W-1:0]   sel_q, sel_n;

  logic [NUM_REQ-1:0] pick_mask;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_found;
  logic               owner_req;
  logic               below_limit;

  // Owner bit is excluded from the search only while someone holds the grant.
  assign pick_mask = (state == S_GRANT) ? (NUM_REQ'(1) << sel_q) : '0;

  rr_pick32 u_pick (
    .req   (bus.req),
    .mask  (pick_mask),
    .start (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign owner_req   = bus.req[sel_q];
  assign below_limit = (MAX_HOLD == 0) || (32'(hold_cnt) < (MAX_HOLD - 32'd1));

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      grant_q  <= '0;
      gv_q     <= 1'b0;
      sel_q    <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      grant_q  <= grant_n;
      gv_q     <= gv_n;
      sel_q    <= sel_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    grant_n = grant_q;
    gv_n    = gv_q;
    sel_n   = sel_q;

    unique case (state)
      S_IDLE: begin
        if (pick_found) begin
          state_n = S_GRANT;
          sel_n   = pick_idx;
          grant_n = NUM_REQ'(1) << pick_idx;
          gv_n    = 1'b1;
          ptr_n   = pick_idx + SEL_W'(1);
          hold_n  = '0;
        end
      end

      S_GRANT: begin
        if (owner_req && below_limit) begin
          // Keep: counter saturates so unlimited holds never wrap.
          if (hold_cnt != {HC_W{1'b1}}) hold_n = hold_cnt + HC_W'(1);
        end else if (pick_found) begin
          // Release or preempt with a successor: hand off on this edge.
          sel_n   = pick_idx;
          grant_n = NUM_REQ'(1) << pick_idx;
          gv_n    = 1'b1;
          ptr_n   = pick_idx + SEL_W'(1);
          hold_n  = '0;
        end else if (owner_req) begin
          // Preempt with no competitor: re-grant the owner, ptr untouched.
          hold_n = '0;
        end else begin
          state_n = S_IDLE;
          grant_n = '0;
          gv_n    = 1'b0;
          hold_n  = '0;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = gv_q;
  assign bus.select      = sel_q;

endmodule

// File: doc/mux32_arbiter.md
# mux32_arbiter

Round-robin arbiter that shares one 32:1 multiplexer among 32 requesters. It drives the mux `select` input so that exactly one requester's data reaches the shared output at a time. Ownership is held while the owner keeps requesting, and a hold limit forces rotation. It sits directly in front of `mux32`. Its `select` output wires straight to the mux select port, and its `grant` vector returns to the requesters.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles one owner keeps the grant. 0 means unlimited.
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req`  in  32: request vector. Bit i is requester i, which maps to mux input `in<i>`.
- `grant`  out  32: one-hot grant, registered. All zeros when there is no owner.
- `grant_valid`  out  1: high while some requester owns the mux. Equals `|grant`.
- `select`  out  5: index of the current owner, registered. Drives `mux32.select`.

## Operation
- Internal state:
  - FSM state.
  - `ptr[4:0]`: search start index.
  - `hold_cnt`: width `$clog2(MAX_HOLD+1)`, minimum 1 bit.
- Pick function: search `req` for the first set bit starting at `ptr` and ascending, wrapping 31 to 0. It returns the index and a `found` flag.
- FSM states:
  - **S_IDLE**
    - No owner.
    - If any `req` bit is set: grant the pick, set `select` to the pick and `ptr` to pick+1 mod 32, clear `hold_cnt`, go to S_GRANT.
    - Otherwise stay.
  - **S_GRANT**
    - Owner is `select`.
    - *Keep* when `req[select]`=1 and (`MAX_HOLD`=0 or `hold_cnt` < `MAX_HOLD`-1). Increment `hold_cnt` (saturating when `MAX_HOLD`=0) and stay.
    - *Release* when `req[select]`=0. Pick among `req` with the owner bit masked off.
      - If found: switch to that requester in the same edge, with no idle bubble.
      - If not found: go to S_IDLE and clear `grant`.
    - *Preempt* when `req[select]`=1 and `hold_cnt` = `MAX_HOLD`-1. Pick with the owner bit masked off.
      - If another requester is found: switch to it.
      - If not: the owner is re-granted, `hold_cnt` clears and `ptr` is unchanged.
- On every new grant, `ptr` becomes winner+1 mod 32. Index 31 wraps `ptr` to 0.
- The arbiter never grants a requester whose `req` bit is 0 on the deciding edge.
- Fairness: a continuously asserted requester is granted within 31 grants of others.

## Timing
- All outputs are registered. Reset values:
  - `grant`=0, `grant_valid`=0, `select`=0
  - `ptr`=0, `hold_cnt`=0, state S_IDLE
- Latency from `req` rising (sampled at edge k) to grant visible: after edge k, i.e. 1 cycle.
- Owner handoff is 1 cycle. The new `select` is valid right after the edge on which the release or preempt is detected.
- `select` is stable for the whole time `grant_valid`=1 with the same owner. Mux data for the owner is valid 1 mux propagation delay after each edge.
- Simultaneous events:
  - If the owner drops and new requests arrive on the same edge, the new requests take part in that pick.
  - If the owner drops on the same edge that `hold_cnt` hits the limit, it is treated as a release.
- Reset asserted mid-grant clears all outputs immediately, without waiting for a clock edge. The first grant after reset deasserts searches from index 0.
- `MAX_HOLD`=1 gives strict round-robin: each edge rotates whenever another requester is present.

## Structure
- Package `mux32_arb_pkg`:
  - `NUM_REQ`=32
  - `SEL_W`=5
  - `typedef enum logic {S_IDLE, S_GRANT} arb_state_t`
- Sub-module `rr_pick32`, purely combinational.
  - Inputs: `req[31:0]`, `mask[31:0]`, `start[4:0]`.
  - Outputs: `idx[4:0]`, `found`.
  - Implementation: rotate, priority-encode, un-rotate.
- `mux32_arbiter` holds the FSM, `ptr`, `hold_cnt` and the output registers.

## Test plan
- **Reset and single request:** reset, then `req`=0x0000_0010. After 1 edge: `grant`=0x10, `select`=4, `grant_valid`=1. Drop `req`; after 1 edge `grant_valid`=0.
- **Round-robin order:** `req`=0x8000_0003 held constant with `MAX_HOLD`=1. Grants cycle 0, 1, 31, 0, 1, …, one per cycle, with `select` wrapping 31 to 0.
- **Hold and preempt:** `MAX_HOLD`=4, `req`=0x0000_0005 held. Requester 0 is granted 4 cycles, then requester 2 for 4 cycles, then 0 again.
- **Lone owner re-grant:** `MAX_HOLD`=4, `req`=0x0000_0100 held 12 cycles. `select`=8 is continuous and `grant_valid` never drops.
- **Handoff without bubble:** owner 3 drops `req` on the same edge requester 20 asserts. The next cycle shows `select`=20 and `grant_valid` stays 1 throughout.
- **Async reset mid-grant:** assert `rst` between edges while `select`=7. `grant`, `select` and `grant_valid` read 0 before the next `clk` edge. After release with `req`=0xFFFF_FFFF, the first grant is index 0.
